spi_frame_loader: RTL and testbench

- Upstream feeder for the cube scan controller.
- Receives frame data from the host over a mode-0 SPI link on header GPIO and writes it byte by byte into the back bank of the double-buffered frame memory.
- Requests a bank swap on host command. The scan controller reads the front bank and acknowledges the swap at end of scan.

---
 rtl/spi_frame_loader.sv | 209 ++++++++++++++++++++
 tb/tb_spi_frame_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_loader.sv
// SPI mode-0 receiver that loads frame bytes into the back bank of a double-buffered
// frame memory and hands bank swaps to the scan controller.
module spi_frame_loader #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned FRAME_BYTES = 4096,
    parameter logic [7:0]  CMD_DATA    = 8'h01,
    parameter logic [7:0]  CMD_COMMIT  = 8'h02
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH:0]   mem_wr_addr,
    output logic [7:0]            mem_wr_data,
    output logic                  swap_req,
    input  logic                  swap_ack,
    output logic                  front_bank,
    output logic                  frame_done,
    output logic                  overrun
);

    // One extra address bit so the counter can sit at FRAME_BYTES once the frame is full.
    localparam logic [ADDR_WIDTH:0] FRAME_END = (ADDR_WIDTH + 1)'(FRAME_BYTES);
    localparam logic [ADDR_WIDTH:0] ADDR_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StIgnore,
        StWaitSwap
    } state_e;

    logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_rise, cs_fall, cs_rise;

    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_byte;
    logic       byte_done;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH:0]   wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  swap_req_q, swap_req_d;
    logic                  front_q, front_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;

    // cs_n synchronisers reset high so release of reset never looks like a select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    assign rx_byte   = {shift_q, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // Deselect clears the bit count, which also drops any partial byte.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (sclk_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (cs_s) begin
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= 7'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        swap_req_d = swap_req_q;
        front_d    = front_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (byte_done) begin
                    if (rx_byte == CMD_DATA) begin
                        state_d = StData;
                        addr_d  = '0;
                    end else if (rx_byte == CMD_COMMIT) begin
                        state_d    = StWaitSwap;
                        swap_req_d = 1'b1;
                    end else begin
                        state_d = StIgnore;
                    end
                end
                // A commit survives deselect; everything else returns to idle.
                if (cs_rise && (state_d != StWaitSwap)) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (byte_done) begin
                    if (addr_q == FRAME_END) begin
                        overrun_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {~front_q, addr_q[ADDR_WIDTH-1:0]};
                        wr_data_d = rx_byte;
                        addr_d    = addr_q + ADDR_ONE;
                    end
                end
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            StIgnore: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            StWaitSwap: begin
                if (cs_fall) begin
                    overrun_d = 1'b1;
                end
                if (swap_ack) begin
                    front_d    = ~front_q;
                    swap_req_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = cs_s ? StIdle : StIgnore;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            swap_req_q <= 1'b0;
            front_q    <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            swap_req_q <= swap_req_d;
            front_q    <= front_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign swap_req    = swap_req_q;
    assign front_bank  = front_q;
    assign frame_done  = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Bench for spi_frame_loader: directed vector table, hand-written timing sequences and
// random transactions checked against a transaction-level model of the loader.
module tb_spi_frame_loader;

    localparam int         AW         = 6;
    localparam int         FB         = 40;
    localparam logic [7:0] CMD_DATA   = 8'h01;
    localparam logic [7:0] CMD_COMMIT = 8'h02;

    typedef logic [AW+8:0] wr_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        int          n;
        int          partial;
        int          exp_writes;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_sclk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          swap_ack = 1'b0;
    logic          mem_wr_en;
    logic [AW:0]   mem_wr_addr;
    logic [7:0]    mem_wr_data;
    logic          swap_req;
    logic          front_bank;
    logic          frame_done;
    logic          overrun;

    spi_frame_loader #(
        .ADDR_WIDTH (AW),
        .FRAME_BYTES(FB),
        .CMD_DATA   (CMD_DATA),
        .CMD_COMMIT (CMD_COMMIT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .front_bank (front_bank),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    logic [7:0] tx_bytes[$];
    int   wide_cnt = 0;
    int   fd_cnt = 0;
    logic wr_prev = 1'b0;
    logic fd_prev = 1'b0;

    // Model state: displayed bank, sticky error, and whether a swap is pending.
    logic m_front = 1'b0;
    logic m_ovr   = 1'b0;
    logic m_wait  = 1'b0;

    always @(negedge clk) begin
        if (mem_wr_en) got_q.push_back({mem_wr_addr, mem_wr_data});
        if (mem_wr_en && wr_prev) wide_cnt <= wide_cnt + 1;
        if (frame_done && !fd_prev) fd_cnt <= fd_cnt + 1;
        wr_prev <= mem_wr_en;
        fd_prev <= frame_done;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        tick(2);
        spi_sclk = 1'b1;
        tick(2);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic send_tx(input logic [7:0] cmd, input int partial);
        spi_cs_n = 1'b0;
        tick(4);
        spi_byte(cmd);
        foreach (tx_bytes[i]) spi_byte(tx_bytes[i]);
        for (int i = 0; i < partial; i++) spi_bit(1'($urandom));
        tick(1);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    // Expected effect of one whole transaction, from the loader's externally visible rules.
    task automatic model_tx(input logic [7:0] cmd);
        if (m_wait) begin
            m_ovr = 1'b1;
        end else if (cmd == CMD_DATA) begin
            foreach (tx_bytes[i]) begin
                if (i < FB) exp_q.push_back({~m_front, AW'(i), tx_bytes[i]});
                else m_ovr = 1'b1;
            end
        end else if (cmd == CMD_COMMIT) begin
            m_wait = 1'b1;
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, " write count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, " write addr/data"}, got_q.pop_front(), exp_q.pop_front());
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, " overrun"}, overrun, m_ovr);
        chk({tag, " swap_req"}, swap_req, m_wait);
        chk({tag, " front_bank"}, front_bank, m_front);
    endtask

    task automatic run_tx(input string tag, input logic [7:0] cmd, input int partial);
        model_tx(cmd);
        send_tx(cmd, partial);
        check_writes(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " mem_wr_en"}, mem_wr_en, 0);
        chk({tag, " mem_wr_addr"}, mem_wr_addr, 0);
        chk({tag, " mem_wr_data"}, mem_wr_data, 0);
        chk({tag, " swap_req"}, swap_req, 0);
        chk({tag, " front_bank"}, front_bank, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        chk({tag, " overrun"}, overrun, 0);
    endtask

    vec_t       vecs[7];
    logic [7:0] lat_byte;
    logic [7:0] rnd_cmd;
    int         fd_before;

    initial begin
        vecs[0] = '{cmd: CMD_DATA, data: 32'hA53C0000, n: 2, partial: 0, exp_writes: 2};
        vecs[1] = '{cmd: CMD_DATA, data: 32'h11000000, n: 1, partial: 5, exp_writes: 1};
        vecs[2] = '{cmd: 8'h7E,    data: 32'hDEADBE00, n: 3, partial: 0, exp_writes: 0};
        vecs[3] = '{cmd: CMD_DATA, data: 32'h00FF8001, n: 4, partial: 0, exp_writes: 4};
        vecs[4] = '{cmd: 8'h00,    data: 32'h12340000, n: 2, partial: 0, exp_writes: 0};
        vecs[5] = '{cmd: 8'hFF,    data: 32'h55000000, n: 1, partial: 3, exp_writes: 0};
        vecs[6] = '{cmd: CMD_DATA, data: 32'h00000000, n: 0, partial: 7, exp_writes: 0};

        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(4);

        // Byte latency: write strobe appears on the 4th negedge after the 8th SCLK rise.
        lat_byte = 8'h5A;
        tx_bytes = {lat_byte};
        model_tx(CMD_DATA);
        spi_cs_n = 1'b0;
        tick(4);
        spi_byte(CMD_DATA);
        for (int i = 7; i >= 1; i--) spi_bit(lat_byte[i]);
        spi_mosi = lat_byte[0];
        tick(2);
        spi_sclk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("latency cycle %0d", i), mem_wr_en, (i == 3) ? 1 : 0);
        end
        tick(1);
        spi_sclk = 1'b0;
        tick(2);
        spi_cs_n = 1'b1;
        tick(8);
        check_writes("latency");

        foreach (vecs[v]) begin
            tx_bytes.delete();
            for (int i = 0; i < vecs[v].n; i++) tx_bytes.push_back(vecs[v].data[31-8*i -: 8]);
            model_tx(vecs[v].cmd);
            send_tx(vecs[v].cmd, vecs[v].partial);
            chk($sformatf("vec%0d writes", v), got_q.size(), vecs[v].exp_writes);
            check_writes($sformatf("vec%0d", v));
        end

        // Last data bit and deselect reach the synchronisers together.
        lat_byte = 8'hC3;
        tx_bytes = {lat_byte};
        model_tx(CMD_DATA);
        spi_cs_n = 1'b0;
        tick(4);
        spi_byte(CMD_DATA);
        for (int i = 7; i >= 1; i--) spi_bit(lat_byte[i]);
        spi_mosi = lat_byte[0];
        tick(2);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        tick(4);
        spi_sclk = 1'b0;
        tick(8);
        check_writes("same-cycle");

        for (int t = 0; t < 25; t++) begin
            tx_bytes.delete();
            repeat ($urandom_range(0, 10)) tx_bytes.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                rnd_cmd = CMD_DATA;
            end else begin
                rnd_cmd = 8'($urandom);
                if (rnd_cmd == CMD_DATA || rnd_cmd == CMD_COMMIT) rnd_cmd = 8'h80;
            end
            run_tx($sformatf("rand%0d", t), rnd_cmd, int'($urandom_range(0, 7)));
        end

        // Commit: request held through 20 idle-ack cycles, then one ack swaps banks.
        tx_bytes.delete();
        fd_before = fd_cnt;
        run_tx("commit", CMD_COMMIT, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("swap_req held %0d", i), swap_req, 1);
        end
        @(posedge clk);
        #1 swap_ack = 1'b1;
        @(posedge clk);
        #1 swap_ack = 1'b0;
        m_front = ~m_front;
        m_wait  = 1'b0;
        tick(3);
        chk("swap swap_req", swap_req, 0);
        chk("swap front_bank", front_bank, 1);
        chk("swap frame_done pulses", fd_cnt - fd_before, 1);

        fd_before = fd_cnt;
        swap_ack = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        tick(3);
        chk("stray ack front_bank", front_bank, 1);
        chk("stray ack frame_done", fd_cnt - fd_before, 0);

        tx_bytes = {8'h9B, 8'h42};
        run_tx("after swap", CMD_DATA, 0);

        // A transaction while the swap is pending is dropped and flags overrun.
        tx_bytes.delete();
        run_tx("commit2", CMD_COMMIT, 0);
        tx_bytes = {8'hE1, 8'hE2};
        run_tx("during wait", CMD_DATA, 0);

        spi_cs_n = 1'b0;
        tick(4);
        spi_byte(CMD_DATA);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        #3 reset_n = 1'b0;
        #1 check_all_zero("async reset");
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(4);
        got_q.delete();
        exp_q.delete();
        m_front = 1'b0;
        m_ovr   = 1'b0;
        m_wait  = 1'b0;
        tx_bytes = {8'h77};
        run_tx("post reset", CMD_DATA, 0);

        // Full frame plus two: the surplus bytes are dropped and the address saturates.
        tx_bytes.delete();
        for (int i = 0; i < FB + 2; i++) tx_bytes.push_back(8'($urandom));
        run_tx("overflow", CMD_DATA, 0);
        tx_bytes = {8'h3D};
        run_tx("after overflow", CMD_DATA, 0);

        chk("write strobe width", wide_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
